// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared types and defaults for the I2C register controller
//
// Purpose: holds the controller state enum and the default register-file
// geometry used by i2c_reg_ctrl and i2c_reg_ptr.
// Ports: none (package).
// Build option: I2C_REG_AUTO_INC_EN (see i2c_reg_ctrl.sv).
package i2c_pkg;

  localparam int NUM_REGS_DEFAULT = 16;
  localparam int REG_AW_DEFAULT   = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PTR   = 2'd1,
    ST_WRITE = 2'd2,
    ST_READ  = 2'd3
  } state_e;

endpackage

// File: rtl/i2c_reg_ptr.sv
// rtl/i2c_reg_ptr.sv - register pointer with load, increment and wrap
//
// Purpose: holds the register pointer. A load takes priority over an
// increment; the increment wraps naturally because the register count is a
// power of two and the pointer is exactly REG_AW bits wide.
// Ports:
//   clk, reset  - clock, synchronous active-high reset (pointer -> 0)
//   load        - load load_val into the pointer
//   load_val    - value to load
//   inc         - advance the pointer by one, modulo 2**REG_AW
//   ptr         - current pointer
module i2c_reg_ptr #(
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [REG_AW-1:0] load_val,
  input  logic              inc,
  output logic [REG_AW-1:0] ptr
);

  logic [REG_AW-1:0] ptr_q;
  logic [REG_AW-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (load) begin
      ptr_d = load_val;
    end else if (inc) begin
      ptr_d = ptr_q + REG_AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/i2c_reg_ctrl.sv
// rtl/i2c_reg_ctrl.sv - I2C slave register-access controller
//
// Purpose: turns byte-level I2C slave events into register-file accesses.
// A host write sets the pointer with its first data byte, then each further
// byte is written to the pointed register. A host read streams the pointed
// register out on tx_data.
// Build option: I2C_REG_AUTO_INC_EN - when defined the pointer advances after
// every register write and every tx_req in READ; otherwise it only changes
// on a pointer load or reset.
// Ports:
//   clk, reset           - clock, synchronous active-high reset
//   bus_start, bus_stop  - START/repeated START and STOP pulses
//   rw                   - direction with bus_start (1 = host reads)
//   rx_valid, rx_data    - received data byte
//   tx_req               - peripheral consumed tx_data
//   tx_data              - byte offered for host reads
//   reg_addr             - register address (the pointer)
//   reg_wdata, reg_wr    - register write data and strobe
//   reg_rdata            - register read data (combinational from reg_addr)
//   err_clr, err         - sticky protocol error flag and its clear
//   busy                 - controller not idle
module i2c_reg_ctrl
  import i2c_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEFAULT,
  parameter int REG_AW   = REG_AW_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bus_start,
  input  logic              bus_stop,
  input  logic              rw,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              tx_req,
  output logic [7:0]        tx_data,
  output logic [REG_AW-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_wr,
  input  logic [7:0]        reg_rdata,
  input  logic              err_clr,
  output logic              err,
  output logic              busy
);

  state_e      state_q, state_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic [7:0]  reg_wdata_q, reg_wdata_d;
  logic        reg_wr_q, reg_wr_d;
  logic        err_q, err_d;
  logic        err_set;
  logic        ptr_load;
  logic        ptr_inc;
  logic [REG_AW-1:0] ptr;

  // Byte actions are decided from the current state first; START/STOP then
  // override only the state transition, so a byte arriving with a bus event
  // still completes.
  always_comb begin
    state_d     = state_q;
    tx_data_d   = tx_data_q;
    reg_wdata_d = reg_wdata_q;
    reg_wr_d    = 1'b0;
    err_set     = 1'b0;
    ptr_load    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rx_valid) err_set = 1'b1;
      end
      ST_PTR: begin
        if (rx_valid) begin
          ptr_load = 1'b1;
          state_d  = ST_WRITE;
          // Out-of-range pointer is flagged but the truncated value is kept.
          if (int'(rx_data) >= NUM_REGS) err_set = 1'b1;
        end
      end
      ST_WRITE: begin
        if (rx_valid) begin
          reg_wr_d    = 1'b1;
          reg_wdata_d = rx_data;
        end
      end
      ST_READ: begin
        tx_data_d = reg_rdata;
        if (rx_valid) err_set = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (tx_req && (state_q != ST_READ)) err_set = 1'b1;

    // START beats a coincident STOP (repeated START).
    if (bus_start) begin
      state_d = rw ? ST_READ : ST_PTR;
    end else if (bus_stop) begin
      state_d = ST_IDLE;
    end

    // A new error outranks a clear in the same cycle.
    err_d = err_set | (err_q & ~err_clr);
  end

  // The write pulse is visible one cycle after the byte; the pointer moves
  // at the end of that pulse so reg_addr is stable while reg_wr is high.
`ifdef I2C_REG_AUTO_INC_EN
  assign ptr_inc = reg_wr_q | ((state_q == ST_READ) & tx_req);
`else
  assign ptr_inc = 1'b0;
`endif

  i2c_reg_ptr #(
    .REG_AW(REG_AW)
  ) u_ptr (
    .clk      (clk),
    .reset    (reset),
    .load     (ptr_load),
    .load_val (rx_data[REG_AW-1:0]),
    .inc      (ptr_inc),
    .ptr      (ptr)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      tx_data_q   <= 8'h00;
      reg_wdata_q <= 8'h00;
      reg_wr_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      tx_data_q   <= tx_data_d;
      reg_wdata_q <= reg_wdata_d;
      reg_wr_q    <= reg_wr_d;
      err_q       <= err_d;
    end
  end

  // A reset arriving while a write pulse is pending suppresses that write.
  assign reg_wr    = reg_wr_q & ~reset;
  assign reg_wdata = reg_wdata_q;
  assign reg_addr  = ptr;
  assign tx_data   = tx_data_q;
  assign err       = err_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: doc/i2c_reg_ctrl.md
I2C_REG_CTRL -- requirements
Module: i2c_reg_ctrl

Interface
REQ-001 SHALL have parameter NUM_REGS, default 16: number of addressable registers, power of two.
REQ-002 SHALL have parameter REG_AW, default 4: register pointer width, equal to log2(NUM_REGS).
REQ-003 SHALL use one clock and a synchronous, active-high reset; the port lines below are fixed.
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- bus_start  in  1  one-cycle pulse; START or repeated START detected, already synchronized to clk
- bus_stop  in  1  one-cycle pulse; STOP detected
- rw  in  1  transfer direction, valid with bus_start: 0 = host writes, 1 = host reads
- rx_valid  in  1  one-cycle pulse; received data byte complete (address byte excluded)
- rx_data  in  8  received byte, valid with rx_valid
- tx_req  in  1  one-cycle pulse; peripheral consumed tx_data and needs the next byte
- tx_data  out  8  byte presented to peripheral for host reads
- reg_addr  out  REG_AW  register file address, equal to the pointer
- reg_wdata  out  8  register write data
- reg_wr  out  1  one-cycle register write strobe
- reg_rdata  in  8  register file read data, combinational from reg_addr
- err_clr  in  1  clears err
- err  out  1  sticky protocol error flag
- busy  out  1  high whenever state is not IDLE

Function
REQ-004 SHALL implement states IDLE, PTR, WRITE and READ.
REQ-005 bus_start with rw=0 SHALL move any state to PTR; bus_start with rw=1 SHALL move any state to READ with the pointer retained.
REQ-006 bus_stop SHALL move any state to IDLE; the pointer is retained across STOP.
REQ-007 In PTR, rx_valid SHALL load pointer <= rx_data[REG_AW-1:0] and move to WRITE; rx_data >= NUM_REGS SHALL set err; the truncated value is still used.
REQ-008 In WRITE, each rx_valid SHALL produce exactly one reg_wr pulse on the next cycle, with reg_addr = current pointer and reg_wdata = rx_data; the pointer then advances per REQ-014.
REQ-009 In READ, tx_data SHALL register reg_rdata every cycle, so tx_data reflects the pointed register 2 cycles after READ entry or after tx_req.
REQ-010 In READ, tx_req SHALL advance the pointer per REQ-014.
REQ-011 Pointer increment SHALL wrap modulo NUM_REGS: NUM_REGS-1 -> 0.
REQ-012 Each of the following SHALL set err and is otherwise ignored:
- rx_valid in IDLE or READ
- tx_req outside READ (tx_data unchanged)
REQ-013 Simultaneous events:
- rx_valid together with bus_stop or bus_start SHALL complete the byte action first, then take the transition.
- bus_stop together with bus_start SHALL resolve as bus_start (repeated START).
- err_clr together with an error-setting event SHALL leave err=1.
REQ-014 Pointer advance SHALL occur only where REQ-008/REQ-010 specify and only under I2C_REG_AUTO_INC_EN.

Reset
REQ-015 Reset SHALL force:
- state=IDLE, pointer=0
- tx_data=0, reg_wr=0, reg_wdata=0
- err=0, busy=0
REQ-016 Reset mid-transaction SHALL abort without issuing a pending reg_wr.

Configuration
REQ-017 With macro I2C_REG_AUTO_INC_EN defined, the pointer SHALL increment after each write and each tx_req; undefined, the pointer SHALL change only via PTR load and reset.

Structure
REQ-018 Package i2c_pkg SHALL hold the state enum typedef and the NUM_REGS/REG_AW defaults.
REQ-019 The pointer (load, increment, wrap) SHALL be a sub-module i2c_reg_ptr; no other sub-modules.

Verification
REQ-020 A bench SHALL cover these directed scenarios:
- start(rw=0), rx 0x03, 0xAA, 0xBB, stop -> reg_wr at addr 3 data 0xAA, addr 4 data 0xBB; busy falls after stop.
- write ptr 0x0F, then start(rw=1) with reg[15]=0x5A, reg[0]=0x11, tx_req once -> tx_data 0x5A, then 0x11 (wrap).
- start(rw=0), rx 0x13 -> err=1, pointer=3; err_clr -> err=0.
- rx_valid 0x77 in the same cycle as bus_stop in WRITE, ptr=2 -> reg_wr addr 2 data 0x77, then IDLE.
- reset asserted in the cycle after rx_valid in WRITE -> no reg_wr; all outputs at reset values.
- macro undefined: ptr 5, rx 0x01, 0x02 -> both writes at addr 5.
